bn_stat_ctrl: RTL and testbench
===============================

Name: bn_stat_ctrl

Overview:
Sequencing controller for the 8-lane batch-norm statistics datapath (input registers, mux, adder trees, sum/sum-of-products accumulators). It runs one statistics pass over a mini-batch of 2^beats_log2 beats of 8 samples each: it clears the accumulators, accepts beats over a valid/ready handshake, times the accumulator enables against the datapath pipeline, drains, and captures mean1/mean2 by shift-divide. It also drives the forward/backward select (x^2 vs dy*x) for the whole pass.

Parameters:
N, 16, sample width
LANES_LOG2, 3, log2 of lanes per beat (8 lanes)
MAX_LOG2, 5, maximum beats_log2; larger requests are clamped
PIPE_LAT, 1, cycles from beat acceptance to the matching datapath accumulator-enable cycle (1..4)
A1_W, N+LANES_LOG2+MAX_LOG2, width of the first-moment accumulator
A2_W, 2*N+LANES_LOG2+MAX_LOG2, width of the second-moment accumulator

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pass request pulse; sampled only in IDLE
abort  in  1  cancel current pass
mode  in  1  0=forward (x*x), 1=backward (dy*x); latched at start
beats_log2  in  3  log2 beats per pass; latched at start
in_valid  in  1  upstream beat valid
in_ready  out  1  controller accepts beat
in_load  out  1  load enable for datapath input registers (=in_valid&in_ready)
sel  out  1  datapath mux select (latched mode)
acc_clr  out  1  synchronous clear of both accumulators
acc_en  out  1  accumulate enable
acc1_q  in  A1_W  first-moment accumulator value
acc2_q  in  A2_W  second-moment accumulator value
busy  out  1  pass in progress
done  out  1  one-cycle pulse, means valid
mean1  out  N  sum(x)/(8*2^L), truncated
mean2  out  2N  sum(products)/(8*2^L), truncated
beat_cnt  out  MAX_LOG2+1  beats accepted in current pass

Behaviour:
- Reset (synchronous, active-high): state IDLE; in_ready, in_load, acc_en, acc_clr, busy, done = 0; sel = 0; mean1, mean2, beat_cnt = 0; enable delay line cleared.
- States: IDLE, CLEAR, RUN, DRAIN, CAPTURE.
- IDLE: busy=0, in_ready=0. start=1 -> latch mode into sel; latch L = min(beats_log2, MAX_LOG2); beat_cnt <= 0; next CLEAR. start in any other state is ignored.
- CLEAR: one cycle; acc_clr=1, busy=1; next RUN.
- RUN: in_ready=1, busy=1. A fire is in_valid&in_ready; on fire, beat_cnt++ and in_load=1. Gaps on in_valid are allowed, with no limit. On the fire where beat_cnt == 2^L-1, next state is DRAIN and in_ready drops in the following cycle.
- acc_en = fire delayed exactly PIPE_LAT cycles through a shift register. The shift register keeps running through DRAIN.
- DRAIN: busy=1, in_ready=0. Lasts exactly PIPE_LAT cycles, then CAPTURE.
- CAPTURE: one cycle, busy=1. Registers mean1 <= acc1_q >> (LANES_LOG2+L) and mean2 <= acc2_q >> (LANES_LOG2+L), low N / 2N bits. Next IDLE; done=1 in that first IDLE cycle, with means valid.
- Latency: last fire at cycle t -> done at t+PIPE_LAT+2.
- mean1/mean2 hold until the next CAPTURE or reset.
- abort: in CLEAR/RUN/DRAIN/CAPTURE -> next state IDLE with acc_clr=1 for one cycle. Delay line cleared, no done, means unchanged, busy=0 next cycle. In IDLE, abort is ignored. abort wins over start and over fire in the same cycle; that beat is not counted.
- done and start in the same cycle: start accepted (done pulse in IDLE).
- L=0: single beat; RUN exits on the first fire.
- Reset mid-pass: immediate return to the reset state next cycle. The accumulators are cleared by the next pass's CLEAR.

Test Plan:
- Forward, L=0, PIPE_LAT=1, all x=4, datapath model attached -> acc1=32, acc2=128; mean1=4, mean2=16; done exactly 3 cycles after the fire; one acc_clr pulse before it.
- L=2, x lanes = beat index+1 (beats 1..4), in_valid gapped 1-of-2 -> 4 fires, beat_cnt=4, acc1=80, mean1=2 (80>>5), acc_en pulses exactly 4 at fire+1.
- Backward mode=1, L=1, x=2, dy=3 -> sel=1 whole pass; acc2=96, mean2=6.
- beats_log2=7 with MAX_LOG2=5 -> clamped, exactly 32 fires before DRAIN; start pulsed during RUN ignored.
- abort at beat 3 of 4, then new pass L=0 with x=1 -> no done for the aborted pass, acc_clr pulse, old means held; new pass mean1=1, mean2=1.
- reset asserted in DRAIN -> all outputs 0 next cycle, no done; the next pass completes correctly.

Source files
------------

// File: rtl/bn_stat_ctrl_if.sv
// Control/status bundle between the batch-norm statistics controller and
// its upstream source plus the accumulator datapath.
interface bn_stat_ctrl_if #(
  parameter int N          = 16,
  parameter int LANES_LOG2 = 3,
  parameter int MAX_LOG2   = 5,
  parameter int A1_W       = N + LANES_LOG2 + MAX_LOG2,
  parameter int A2_W       = 2*N + LANES_LOG2 + MAX_LOG2
);
  logic                  start;
  logic                  abort;
  logic                  mode;
  logic [2:0]            beats_log2;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_load;
  logic                  sel;
  logic                  acc_clr;
  logic                  acc_en;
  logic [A1_W-1:0]       acc1_q;
  logic [A2_W-1:0]       acc2_q;
  logic                  busy;
  logic                  done;
  logic [N-1:0]          mean1;
  logic [2*N-1:0]        mean2;
  logic [MAX_LOG2:0]     beat_cnt;

  modport master (
    output start, abort, mode, beats_log2, in_valid, acc1_q, acc2_q,
    input  in_ready, in_load, sel, acc_clr, acc_en, busy, done,
           mean1, mean2, beat_cnt
  );

  modport slave (
    input  start, abort, mode, beats_log2, in_valid, acc1_q, acc2_q,
    output in_ready, in_load, sel, acc_clr, acc_en, busy, done,
           mean1, mean2, beat_cnt
  );
endinterface

// File: rtl/bn_stat_ctrl.sv
// Sequencer for one batch-norm statistics pass: clear, accept 2^L beats,
// align accumulate enables to the datapath pipeline, drain, capture means.
module bn_stat_ctrl #(
  parameter int N          = 16,
  parameter int LANES_LOG2 = 3,
  parameter int MAX_LOG2   = 5,
  parameter int PIPE_LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  bn_stat_ctrl_if.slave    bus
);
  localparam int CNT_W = MAX_LOG2 + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE} state_t;

  state_t              state;
  logic [2:0]          l_reg;
  logic [2:0]          l_clamp;
  logic [3:0]          shamt;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [CNT_W-1:0]    last_beat;
  logic [PIPE_LAT-1:0] en_dly;
  logic [1:0]          drain_cnt;
  logic                in_ready_q;
  logic                acc_clr_q;
  logic                busy_q;
  logic                done_q;
  logic                sel_q;
  logic                fire;
  logic [N-1:0]        mean1_q;
  logic [2*N-1:0]      mean2_q;

  // abort takes priority over a beat presented in the same cycle
  always_comb begin
    l_clamp   = (bus.beats_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : bus.beats_log2;
    last_beat = CNT_W'((32'd1 << l_reg) - 32'd1);
    shamt     = 4'(LANES_LOG2) + {1'b0, l_reg};
    fire      = bus.in_valid & in_ready_q & ~bus.abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      l_reg      <= '0;
      beat_cnt_q <= '0;
      en_dly     <= '0;
      drain_cnt  <= '0;
      in_ready_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= 1'b0;
      mean1_q    <= '0;
      mean2_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      en_dly    <= (en_dly << 1) | PIPE_LAT'(fire);

      if (bus.abort && state != IDLE) begin
        state      <= IDLE;
        acc_clr_q  <= 1'b1;
        en_dly     <= '0;
        busy_q     <= 1'b0;
        in_ready_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              sel_q      <= bus.mode;
              l_reg      <= l_clamp;
              beat_cnt_q <= '0;
              acc_clr_q  <= 1'b1;
              busy_q     <= 1'b1;
              state      <= CLEAR;
            end
          end
          CLEAR: begin
            in_ready_q <= 1'b1;
            state      <= RUN;
          end
          RUN: begin
            if (fire) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
              if (beat_cnt_q == last_beat) begin
                in_ready_q <= 1'b0;
                drain_cnt  <= '0;
                state      <= DRAIN;
              end
            end
          end
          // wait for the last beat's enable to leave the delay line
          DRAIN: begin
            if (drain_cnt == 2'(PIPE_LAT - 1)) begin
              state <= CAPTURE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          CAPTURE: begin
            mean1_q <= N'(bus.acc1_q >> shamt);
            mean2_q <= (2*N)'(bus.acc2_q >> shamt);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.in_load  = bus.in_valid & in_ready_q;
  assign bus.sel      = sel_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.acc_en   = en_dly[PIPE_LAT-1];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mean1    = mean1_q;
  assign bus.mean2    = mean2_q;
  assign bus.beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_bn_stat_ctrl.sv
// Bench for bn_stat_ctrl with a behavioural 8-lane datapath stand-in and
// pass-level reference sums for the expected means and timing.
module tb_bn_stat_ctrl;
  localparam int N    = 16;
  localparam int LL   = 3;
  localparam int ML   = 5;
  localparam int PL   = 1;
  localparam int A1_W = N + LL + ML;
  localparam int A2_W = 2*N + LL + ML;
  localparam int M2W  = 2*N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bn_stat_ctrl_if #(.N(N), .LANES_LOG2(LL), .MAX_LOG2(ML)) bus ();

  bn_stat_ctrl #(.N(N), .LANES_LOG2(LL), .MAX_LOG2(ML), .PIPE_LAT(PL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit in_run = 1'b0;
  logic [N-1:0]   exp_m1 = '0;
  logic [M2W-1:0] exp_m2 = '0;

  logic [N-1:0]    x_in [8];
  logic [N-1:0]    dy_in [8];
  logic [N-1:0]    xr [8];
  logic [N-1:0]    dyr [8];
  logic [A1_W-1:0] acc1_m = '0;
  logic [A2_W-1:0] acc2_m = '0;

  assign bus.acc1_q = acc1_m;
  assign bus.acc2_q = acc2_m;

  function automatic longint unsigned lane_sum(input logic [N-1:0] a [8]);
    longint unsigned s = 0;
    for (int i = 0; i < 8; i++) s += 64'(a[i]);
    return s;
  endfunction

  function automatic longint unsigned prod_sum(input logic [N-1:0] a [8],
                                               input logic [N-1:0] b [8]);
    longint unsigned s = 0;
    for (int i = 0; i < 8; i++) s += 64'(a[i]) * 64'(b[i]);
    return s;
  endfunction

  // input registers one stage ahead of the accumulators (PIPE_LAT = 1)
  always @(posedge clk) begin
    if (bus.in_load) begin
      xr  <= x_in;
      dyr <= dy_in;
    end
    if (bus.acc_clr) begin
      acc1_m <= '0;
      acc2_m <= '0;
    end else if (bus.acc_en) begin
      acc1_m <= acc1_m + A1_W'(lane_sum(xr));
      acc2_m <= acc2_m + A2_W'(bus.sel ? prod_sum(dyr, xr) : prod_sum(xr, xr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: in_load checked before the edge, acc_en after it
  task automatic cyc();
    bit f;
    #1;
    f = bus.in_valid && in_run && !bus.abort && !reset;
    chk("in_load", bus.in_load, bus.in_valid & in_run);
    @(posedge clk);
    #1;
    cyc_n++;
    chk("acc_en", bus.acc_en, f);
    if (bus.acc_en === 1'b1) en_cnt++;
    if (bus.acc_clr === 1'b1) clr_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask

  task automatic set_beat(input int kind, input int b, input int xv, input int dv);
    for (int i = 0; i < 8; i++) begin
      case (kind)
        0:       begin x_in[i] = N'(xv);      dy_in[i] = N'(dv); end
        1:       begin x_in[i] = N'(b + 1);   dy_in[i] = N'(dv); end
        default: begin x_in[i] = N'($urandom); dy_in[i] = N'($urandom); end
      endcase
    end
  endtask

  task automatic run_pass(input bit md, input int bl, input int kind, input int xv,
                          input int dv, input int gap, input int abort_at,
                          input bit extra_start, input bit rst_drain);
    int L, nb, fires, last_fire, guard, clr0, en0, done0;
    longint unsigned s1, s2;
    bit v, ab, f;
    L = (bl > ML) ? ML : bl;
    nb = 1 << L;
    s1 = 0; s2 = 0; fires = 0; last_fire = 0; guard = 0;
    clr0 = clr_cnt; en0 = en_cnt; done0 = done_cnt;

    bus.start = 1'b1; bus.mode = md; bus.beats_log2 = 3'(bl);
    cyc();
    bus.start = 1'b0; bus.mode = ~md;
    chk("clear_busy", bus.busy, 1);
    chk("clear_acc_clr", bus.acc_clr, 1);
    chk("clear_ready", bus.in_ready, 0);
    chk("clear_done", bus.done, 0);
    chk("clear_beat_cnt", bus.beat_cnt, 0);
    cyc();
    in_run = 1'b1;

    while (fires < nb && guard < 4000) begin
      set_beat(kind, fires, xv, dv);
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 1;
        default: v = $urandom_range(1) == 1;
      endcase
      ab = (abort_at == fires) && v;
      bus.abort = ab;
      bus.in_valid = v;
      if (extra_start && fires == 2) bus.start = 1'b1;
      chk("run_ready", bus.in_ready, 1);
      chk("run_sel", bus.sel, md);
      chk("run_busy", bus.busy, 1);
      chk("run_beat_cnt", bus.beat_cnt, fires);
      f = v && !ab;
      if (f) begin
        s1 += lane_sum(x_in);
        s2 += md ? prod_sum(dy_in, x_in) : prod_sum(x_in, x_in);
        last_fire = cyc_n;
      end
      cyc();
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.abort = 1'b0;
      guard++;
      if (ab) begin
        in_run = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_acc_clr", bus.acc_clr, 1);
        chk("abort_ready", bus.in_ready, 0);
        repeat (5) cyc();
        chk("abort_no_done", done_cnt, done0);
        chk("abort_mean1_held", bus.mean1, exp_m1);
        chk("abort_mean2_held", bus.mean2, exp_m2);
        chk("abort_en_count", en_cnt, en0 + fires);
        chk("abort_clr_count", clr_cnt, clr0 + 2);
        return;
      end
      if (f) fires++;
      if (fires == nb) in_run = 1'b0;
    end
    in_run = 1'b0;
    chk("fire_count", fires, nb);
    chk("ready_drop", bus.in_ready, 0);
    chk("final_beat_cnt", bus.beat_cnt, nb);

    if (rst_drain) begin
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_acc_en", bus.acc_en, 0);
      chk("rst_acc_clr", bus.acc_clr, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sel", bus.sel, 0);
      chk("rst_mean1", bus.mean1, 0);
      chk("rst_mean2", bus.mean2, 0);
      chk("rst_beat_cnt", bus.beat_cnt, 0);
      exp_m1 = '0;
      exp_m2 = '0;
      repeat (5) cyc();
      chk("rst_no_done", done_cnt, done0);
      return;
    end

    guard = 0;
    while (done_cnt == done0 && guard < 50) begin
      cyc();
      guard++;
    end
    exp_m1 = N'(s1 >> (LL + L));
    exp_m2 = M2W'(s2 >> (LL + L));
    chk("done_seen", done_cnt, done0 + 1);
    chk("done_latency", done_cyc, last_fire + PL + 2);
    chk("mean1", bus.mean1, exp_m1);
    chk("mean2", bus.mean2, exp_m2);
    chk("done_busy", bus.busy, 0);
    chk("acc1", acc1_m, A1_W'(s1));
    chk("acc2", acc2_m, A2_W'(s2));
    chk("clr_pulses", clr_cnt, clr0 + 1);
    chk("en_pulses", en_cnt, en0 + nb);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.beats_log2 = '0; bus.in_valid = 1'b0;
    set_beat(0, 0, 0, 0);
    repeat (3) cyc();
    chk("reset_busy", bus.busy, 0);
    chk("reset_ready", bus.in_ready, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_acc_clr", bus.acc_clr, 0);
    chk("reset_sel", bus.sel, 0);
    chk("reset_mean1", bus.mean1, 0);
    chk("reset_mean2", bus.mean2, 0);
    chk("reset_beat_cnt", bus.beat_cnt, 0);
    reset = 1'b0;
    cyc();

    run_pass(1'b0, 0, 0, 4, 0, 0, -1, 1'b0, 1'b0);
    chk("A_mean1", bus.mean1, 4);
    chk("A_mean2", bus.mean2, 16);
    chk("A_acc1", acc1_m, 32);
    chk("A_acc2", acc2_m, 128);
    repeat (2) cyc();

    run_pass(1'b0, 2, 1, 0, 0, 1, -1, 1'b0, 1'b0);
    chk("B_acc1", acc1_m, 80);
    chk("B_mean1", bus.mean1, 2);

    // started in the done cycle of the previous pass
    run_pass(1'b1, 1, 0, 2, 3, 0, -1, 1'b0, 1'b0);
    chk("C_acc2", acc2_m, 96);
    chk("C_mean2", bus.mean2, 6);
    repeat (2) cyc();

    run_pass(1'b0, 7, 2, 0, 0, 2, -1, 1'b1, 1'b0);
    repeat (2) cyc();
    run_pass(1'b0, 2, 2, 0, 0, 0, 2, 1'b0, 1'b0);
    run_pass(1'b0, 0, 0, 1, 0, 0, -1, 1'b0, 1'b0);
    chk("F_mean1", bus.mean1, 1);
    chk("F_mean2", bus.mean2, 1);
    repeat (2) cyc();

    run_pass(1'($urandom_range(1)), 3, 2, 0, 0, 2, -1, 1'b0, 1'b1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      run_pass(1'($urandom_range(1)), int'($urandom_range(7)), 2, 0, 0, 2, -1, 1'b0, 1'b0);
      repeat (2) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
